// File: rtl/conv_result_capture.sv
// Captures the first 2x2 result tile from each systolic array and compares them element-wise.
// Optional LATENCY_CNT_EN adds lat3/lat2 registers holding the wait-counter value at each capture.
module conv_result_capture #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              v3_valid,
    input  logic [DATA_W-1:0] c9_11,
    input  logic [DATA_W-1:0] c9_12,
    input  logic [DATA_W-1:0] c9_21,
    input  logic [DATA_W-1:0] c9_22,
    input  logic              v2_valid,
    input  logic [DATA_W-1:0] c4_11,
    input  logic [DATA_W-1:0] c4_12,
    input  logic [DATA_W-1:0] c4_21,
    input  logic [DATA_W-1:0] c4_22,
    output logic [DATA_W-1:0] r9_11,
    output logic [DATA_W-1:0] r9_12,
    output logic [DATA_W-1:0] r9_21,
    output logic [DATA_W-1:0] r9_22,
    output logic [DATA_W-1:0] r4_11,
    output logic [DATA_W-1:0] r4_12,
    output logic [DATA_W-1:0] r4_21,
    output logic [DATA_W-1:0] r4_22,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              timeout,
    output logic [CNT_W-1:0]  lat3,
    output logic [CNT_W-1:0]  lat2
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMP, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic                     got3, got2;
    logic [CNT_W-1:0]         wait_cnt;
    logic [3:0][DATA_W-1:0]   c9, c4, r9, r4;
    logic                     accept, cap3, cap2, both_got, last_cyc;

    // Tiles packed as {o00, o01, o10, o11}
    assign c9 = {c9_11, c9_12, c9_21, c9_22};
    assign c4 = {c4_11, c4_12, c4_21, c4_22};
    assign {r9_11, r9_12, r9_21, r9_22} = r9;
    assign {r4_11, r4_12, r4_21, r4_22} = r4;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign cap3     = (state == S_WAIT) && v3_valid && !got3;
    assign cap2     = (state == S_WAIT) && v2_valid && !got2;
    assign both_got = (got3 || cap3) && (got2 || cap2);
    assign last_cyc = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            // A capture on the final counted cycle still wins over the timeout
            S_WAIT:  if (both_got)      state_nxt = S_CMP;
                     else if (last_cyc) state_nxt = S_DONE;
            S_CMP:   state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_WAIT, S_CMP: busy = 1'b1;
            S_DONE:        done = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            got3     <= 1'b0;
            got2     <= 1'b0;
            wait_cnt <= '0;
            r9       <= '0;
            r4       <= '0;
            match    <= 1'b0;
            timeout  <= 1'b0;
        end else if (accept) begin
            got3     <= 1'b0;
            got2     <= 1'b0;
            wait_cnt <= '0;
            match    <= 1'b0;
            timeout  <= 1'b0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (cap3) begin
                r9   <= c9;
                got3 <= 1'b1;
            end
            if (cap2) begin
                r4   <= c4;
                got2 <= 1'b1;
            end
            if (!both_got && last_cyc) begin
                timeout <= 1'b1;
                match   <= 1'b0;
            end
        end else if (state == S_CMP) begin
            match <= (r9 == r4);
        end
    end

`ifdef LATENCY_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat3 <= '0;
            lat2 <= '0;
        end else if (accept) begin
            lat3 <= '0;
            lat2 <= '0;
        end else begin
            if (cap3) lat3 <= wait_cnt;
            if (cap2) lat2 <= wait_cnt;
        end
    end
`else
    assign lat3 = '0;
    assign lat2 = '0;
`endif

endmodule

// File: tb/tb_conv_result_capture.sv
// Bench for conv_result_capture: directed table of capture runs, randomized runs against a
// first-capture-wins reference model, plus reset and ignored-input sequences.
module tb_conv_result_capture;

    localparam int DW = 8;
    localparam int TO = 64;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic resetn;
    logic start, v3_valid, v2_valid;
    logic [DW-1:0] c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22;
    logic [DW-1:0] r9_11, r9_12, r9_21, r9_22, r4_11, r4_12, r4_21, r4_22;
    logic busy, done, match, timeout;
    logic [CW-1:0] lat3, lat2;

    always #5 clk = ~clk;

    conv_result_capture #(.DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .v3_valid(v3_valid), .c9_11(c9_11), .c9_12(c9_12), .c9_21(c9_21), .c9_22(c9_22),
        .v2_valid(v2_valid), .c4_11(c4_11), .c4_12(c4_12), .c4_21(c4_21), .c4_22(c4_22),
        .r9_11(r9_11), .r9_12(r9_12), .r9_21(r9_21), .r9_22(r9_22),
        .r4_11(r4_11), .r4_12(r4_12), .r4_21(r4_21), .r4_22(r4_22),
        .busy(busy), .done(done), .match(match), .timeout(timeout),
        .lat3(lat3), .lat2(lat2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-WAIT-cycle stimulus for one run
    logic        sv3 [TO];
    logic        sv2 [TO];
    logic [31:0] sd9 [TO];
    logic [31:0] sd4 [TO];
    int          start_k;

    logic [31:0] exp_r9 = '0;
    logic [31:0] exp_r4 = '0;

    typedef struct {
        int          t3, t2, rep3;
        logic [31:0] d9, d4, rep_d;
        int          end_k;
        bit          complete, e_match, e_to;
        logic [31:0] e_r9, e_r4;
        int          l3, l2;
    } vec_t;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    function automatic logic [31:0] r9w();
        return {r9_11, r9_12, r9_21, r9_22};
    endfunction

    function automatic logic [31:0] r4w();
        return {r4_11, r4_12, r4_21, r4_22};
    endfunction

    task automatic put_c9(input logic [31:0] d);
        {c9_11, c9_12, c9_21, c9_22} = d;
    endtask

    task automatic put_c4(input logic [31:0] d);
        {c4_11, c4_12, c4_21, c4_22} = d;
    endtask

    function automatic int exp_lat(input int v);
`ifdef LATENCY_CNT_EN
        return v;
`else
        return v * 0;
`endif
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < TO; k++) begin
            sv3[k] = 1'b0;
            sv2[k] = 1'b0;
            sd9[k] = $urandom;
            sd4[k] = $urandom;
        end
    endtask

    task automatic do_run(input string tag, input int end_k, input bit complete, input bit e_match,
                          input bit e_to, input logic [31:0] e_r9, input logic [31:0] e_r4,
                          input int e_l3, input int e_l2);
        start = 1'b1; v3_valid = 1'b0; v2_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk(tag, "busy_after_start", 32'(busy), 32'd1);
        chk(tag, "timeout_cleared", 32'(timeout), 32'd0);
        for (int k = 0; k <= end_k; k++) begin
            v3_valid = sv3[k]; put_c9(sd9[k]);
            v2_valid = sv2[k]; put_c4(sd4[k]);
            start    = (k == start_k);
            @(posedge clk); #1;
        end
        v3_valid = 1'b0; v2_valid = 1'b0; start = 1'b0;
        if (complete) begin
            chk(tag, "cmp_busy", 32'(busy), 32'd1);
            chk(tag, "cmp_done", 32'(done), 32'd0);
            // Valids and start during the compare cycle must be ignored
            v3_valid = 1'b1; v2_valid = 1'b1; start = 1'b1;
            put_c9($urandom); put_c4($urandom);
            @(posedge clk); #1;
            v3_valid = 1'b0; v2_valid = 1'b0; start = 1'b0;
        end
        chk(tag, "done", 32'(done), 32'd1);
        chk(tag, "busy", 32'(busy), 32'd0);
        chk(tag, "match", 32'(match), 32'(e_match));
        chk(tag, "timeout", 32'(timeout), 32'(e_to));
        chk(tag, "r9", r9w(), e_r9);
        chk(tag, "r4", r4w(), e_r4);
        chk(tag, "lat3", 32'(lat3), exp_lat(e_l3));
        chk(tag, "lat2", 32'(lat2), exp_lat(e_l2));
        v3_valid = 1'b1; v2_valid = 1'b1;
        put_c9($urandom); put_c4($urandom);
        @(posedge clk); #1;
        v3_valid = 1'b0; v2_valid = 1'b0;
        chk(tag, "done_hold", 32'(done), 32'd1);
        chk(tag, "r9_hold", r9w(), e_r9);
        chk(tag, "r4_hold", r4w(), e_r4);
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = '{5, 9, -1, 32'h01020304, 32'h01020304, 0, 9, 1, 1, 0, 32'h01020304, 32'h01020304, 5, 9};
        tbl[1] = '{5, 9, -1, 32'h01020304, 32'h01020305, 0, 9, 1, 0, 0, 32'h01020304, 32'h01020305, 5, 9};
        tbl[2] = '{3, 3, -1, 32'h07070707, 32'h07070707, 0, 3, 1, 1, 0, 32'h07070707, 32'h07070707, 3, 3};
        tbl[3] = '{2, 6, 4, 32'h07070707, 32'h07070707, 32'h09090909, 6, 1, 1, 0, 32'h07070707, 32'h07070707, 2, 6};
        tbl[4] = '{10, -1, -1, 32'h0a0b0c0d, 0, 0, 63, 0, 0, 1, 32'h0a0b0c0d, 32'h07070707, 10, 0};
        tbl[5] = '{63, -1, -1, 32'h11223344, 0, 0, 63, 0, 0, 1, 32'h11223344, 32'h07070707, 63, 0};
        tbl[6] = '{-1, 63, -1, 0, 32'h55667788, 0, 63, 0, 0, 1, 32'h11223344, 32'h55667788, 0, 63};
        tbl[7] = '{63, 63, -1, 32'haabbccdd, 32'haabbccdd, 0, 63, 1, 1, 0, 32'haabbccdd, 32'haabbccdd, 63, 63};
        tbl[8] = '{0, 40, -1, 32'hff00ff00, 32'hff00ff01, 0, 40, 1, 0, 0, 32'hff00ff00, 32'hff00ff01, 0, 40};

        resetn = 1'b0; start = 1'b0; v3_valid = 1'b0; v2_valid = 1'b0;
        put_c9('0); put_c4('0);
        #22;
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        chk("reset", "match", 32'(match), 32'd0);
        chk("reset", "timeout", 32'(timeout), 32'd0);
        chk("reset", "r9", r9w(), 32'd0);
        chk("reset", "r4", r4w(), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Valids in IDLE are ignored
        v3_valid = 1'b1; v2_valid = 1'b1; put_c9(32'h12345678); put_c4(32'h12345678);
        repeat (2) @(posedge clk);
        #1;
        v3_valid = 1'b0; v2_valid = 1'b0;
        chk("idle_ign", "busy", 32'(busy), 32'd0);
        chk("idle_ign", "r9", r9w(), 32'd0);
        chk("idle_ign", "r4", r4w(), 32'd0);

        for (int i = 0; i < 9; i++) begin
            clear_stim();
            if (tbl[i].t3 >= 0) begin sv3[tbl[i].t3] = 1'b1; sd9[tbl[i].t3] = tbl[i].d9; end
            if (tbl[i].t2 >= 0) begin sv2[tbl[i].t2] = 1'b1; sd4[tbl[i].t2] = tbl[i].d4; end
            if (tbl[i].rep3 >= 0) begin sv3[tbl[i].rep3] = 1'b1; sd9[tbl[i].rep3] = tbl[i].rep_d; end
            start_k = 1;
            do_run($sformatf("vec%0d", i), tbl[i].end_k, tbl[i].complete, tbl[i].e_match, tbl[i].e_to,
                   tbl[i].e_r9, tbl[i].e_r4, tbl[i].l3, tbl[i].l2);
        end
        exp_r9 = tbl[8].e_r9;
        exp_r4 = tbl[8].e_r4;

        // Randomized runs; reference: first valid of each array in the window wins
        for (int r = 0; r < 24; r++) begin
            int p3, p2, t3, t2, end_k;
            bit comp, em;
            logic [31:0] base;
            p3 = $urandom_range(0, 8);
            p2 = $urandom_range(0, 8);
            base = $urandom;
            for (int k = 0; k < TO; k++) begin
                sv3[k] = ($urandom_range(0, 99) < p3);
                sv2[k] = ($urandom_range(0, 99) < p2);
                sd9[k] = $urandom_range(0, 1) ? base : $urandom;
                sd4[k] = $urandom_range(0, 1) ? base : $urandom;
            end
            t3 = -1; t2 = -1;
            for (int k = 0; k < TO; k++) begin
                if (sv3[k] && t3 < 0) t3 = k;
                if (sv2[k] && t2 < 0) t2 = k;
            end
            comp  = (t3 >= 0) && (t2 >= 0);
            end_k = comp ? ((t3 > t2) ? t3 : t2) : TO - 1;
            em    = comp && (sd9[t3] == sd4[t2]);
            if (t3 >= 0) exp_r9 = sd9[t3];
            if (t2 >= 0) exp_r4 = sd4[t2];
            start_k = $urandom_range(0, end_k);
            do_run($sformatf("rnd%0d", r), end_k, comp, em, !comp, exp_r9, exp_r4,
                   (t3 >= 0) ? t3 : 0, (t2 >= 0) ? t2 : 0);
        end

        // Asynchronous reset in the middle of WAIT after a 3x3 capture
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        v3_valid = 1'b1; put_c9(32'h5a5a5a5a);
        @(posedge clk); #1;
        v3_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset", "busy", 32'(busy), 32'd0);
        chk("midreset", "done", 32'(done), 32'd0);
        chk("midreset", "match", 32'(match), 32'd0);
        chk("midreset", "timeout", 32'(timeout), 32'd0);
        chk("midreset", "r9_11", 32'(r9_11), 32'd0);
        chk("midreset", "r4", r4w(), 32'd0);
        chk("midreset", "lat3", 32'(lat3), 32'd0);
        @(posedge clk); #1;
        chk("midreset", "busy_hold", 32'(busy), 32'd0);
        resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
